// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

    // Frame receive state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned PS2_CNT_W      = $clog2(PS2_DATA_BITS);

    // Scan-code constants used by downstream decode
    localparam logic [7:0] BREAK     = 8'hF0;
    localparam logic [7:0] EXTEND    = 8'hE0;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length de-glitch filter for one PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             dout_q,  dout_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Output follows the synced line only after FILTER_LEN differing samples in a row
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        dout_d  = dout_q;
        cnt_d   = '0;
        if (sync2_q != dout_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
            end
        end
    end

    // Registers; lines idle high so reset to 1
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dout_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: deserialises 11-bit frames, checks them,
// and keeps the last two good bytes in xkey.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ps2c,
    input  logic        ps2d,
    output logic [15:0] xkey,
    output logic        key_valid,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    logic ps2c_f, ps2d_f;
    logic fall_c;

    ps2_state_e           state_q,      state_d;
    logic                 c_prev_q,     c_prev_d;
    logic [PS2_CNT_W-1:0] cnt_q,        cnt_d;
    logic [7:0]           sr_q,         sr_d;
    logic                 par_q,        par_d;
    logic [TMO_W-1:0]     tmo_q,        tmo_d;
    logic [15:0]          xkey_q,       xkey_d;
    logic                 key_valid_q,  key_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk  (clk),
        .clr  (clr),
        .din  (ps2c),
        .dout (ps2c_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk  (clk),
        .clr  (clr),
        .din  (ps2d),
        .dout (ps2d_f)
    );

    assign fall_c = c_prev_q & ~ps2c_f;

    // Next-state, deserialiser, checks and timeout; timeout outranks a same-cycle fall
    always_comb begin
        state_d      = state_q;
        c_prev_d     = ps2c_f;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        xkey_d       = xkey_q;
        key_valid_d  = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE) begin
            tmo_d = '0;
            if (fall_c && !ps2d_f) begin
                state_d = DATA;
                cnt_d   = '0;
            end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = fall_c ? '0 : TMO_W'(tmo_q + 1'b1);
            if (fall_c) begin
                case (state_q)
                    DATA: begin
                        sr_d  = {ps2d_f, sr_q[7:1]};
                        cnt_d = PS2_CNT_W'(cnt_q + 1'b1);
                        if (cnt_q == PS2_CNT_W'(PS2_DATA_BITS - 1)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        par_d   = ps2d_f;
                        state_d = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        if (!ps2d_f) begin
                            frame_err_d = 1'b1;
                        end else if (^{sr_q, par_q} == 1'b0) begin
                            parity_err_d = 1'b1;
                        end else begin
                            key_valid_d = 1'b1;
                            xkey_d      = {xkey_q[7:0], sr_q};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            c_prev_q     <= 1'b1;
            cnt_q        <= '0;
            sr_q         <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            xkey_q       <= '0;
            key_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_prev_q     <= c_prev_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            xkey_q       <= xkey_d;
            key_valid_q  <= key_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign xkey       = xkey_q;
    assign key_valid  = key_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: good frames, parity/stop errors, timeout,
// glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 25000;
    localparam time         CLK_HALF    = 20ns;
    localparam time         CLK_PER     = 40ns;
    localparam time         PS2_HALF    = 4us;

    logic        clk;
    logic        clr;
    logic        ps2c;
    logic        ps2d;
    logic [15:0] xkey;
    logic        key_valid;
    logic        parity_err;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    int          kv_cnt    = 0;
    int          pe_cnt    = 0;
    int          fe_cnt    = 0;
    int          multi_cnt = 0;
    logic [15:0] kv_xkey   = '0;

    int kv0, pe0, fe0;

    ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .clr        (clr),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .xkey       (xkey),
        .key_valid  (key_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    // Pulse monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt  = kv_cnt + 1;
            kv_xkey = xkey;
        end
        if (parity_err) pe_cnt = pe_cnt + 1;
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (int'(key_valid) + int'(parity_err) + int'(frame_err) > 1) multi_cnt = multi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        kv0 = kv_cnt;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic ps2_bit(input logic b, input logic glitch);
        ps2d = b;
        if (glitch) begin
            #(PS2_HALF / 2);
            ps2c = 1'b0;
            #(3 * CLK_PER);
            ps2c = 1'b1;
            #(PS2_HALF / 2 - 3 * CLK_PER);
        end else begin
            #PS2_HALF;
        end
        ps2c = 1'b0;
        #PS2_HALF;
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int glitch_bit);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i], glitch_bit == i);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, 1'b0);
        ps2d = 1'b1;
        #PS2_HALF;
    endtask

    initial begin
        clr  = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_xkey",       32'(xkey),       32'h0);
        check("reset_key_valid",  32'(key_valid),  32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_frame_err",  32'(frame_err),  32'h0);
        clr = 1'b0;
        repeat (20) @(negedge clk);

        // 1: single good frame 0x29
        snap();
        send_frame(8'h29, 1'b0, 1'b1, -1);
        check("t1_kv_pulses", 32'(kv_cnt - kv0), 32'd1);
        check("t1_xkey",      32'(xkey),         32'h0029);
        check("t1_kv_xkey",   32'(kv_xkey),      32'h0029);
        check("t1_errs",      32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);

        // 2: break sequence F0 29
        snap();
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        check("t2_mid_xkey",  32'(xkey),         32'h29F0);
        send_frame(8'h29, 1'b0, 1'b1, -1);
        check("t2_kv_pulses", 32'(kv_cnt - kv0), 32'd2);
        check("t2_xkey",      32'(xkey),         32'hF029);

        // 3: parity error on 0x1D
        snap();
        send_frame(8'h1D, 1'b0, 1'b1, -1);
        check("t3_parity_err", 32'(pe_cnt - pe0), 32'd1);
        check("t3_no_kv",      32'(kv_cnt - kv0), 32'd0);
        check("t3_xkey_hold",  32'(xkey),         32'hF029);

        // 4: bad stop on 0x23, then good 0x1C
        snap();
        send_frame(8'h23, 1'b0, 1'b0, -1);
        check("t4_frame_err",  32'(fe_cnt - fe0), 32'd1);
        check("t4_no_parity",  32'(pe_cnt - pe0), 32'd0);
        check("t4_no_kv",      32'(kv_cnt - kv0), 32'd0);
        check("t4_xkey_hold",  32'(xkey),         32'hF029);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check("t4_kv",         32'(kv_cnt - kv0), 32'd1);
        check("t4_xkey_low",   32'(xkey[7:0]),    32'h1C);
        check("t4_xkey",       32'(xkey),         32'h291C);

        // 5: abandoned frame after 4 data bits -> timeout
        snap();
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2d = 1'b1;
        repeat (TIMEOUT_CYC - 300) @(negedge clk);
        check("t5_no_early_timeout", 32'(fe_cnt - fe0), 32'd0);
        repeat (500) @(negedge clk);
        check("t5_timeout_err", 32'(fe_cnt - fe0), 32'd1);
        check("t5_no_kv",       32'(kv_cnt - kv0), 32'd0);
        send_frame(8'h1B, 1'b1, 1'b1, -1);
        check("t5_kv",          32'(kv_cnt - kv0), 32'd1);
        check("t5_xkey",        32'(xkey),         32'h1C1B);
        check("t5_errs_after",  32'(fe_cnt - fe0 + pe_cnt - pe0), 32'd1);

        // 6: short low glitch on ps2c mid-bit is rejected
        snap();
        send_frame(8'h29, 1'b0, 1'b1, 3);
        check("t6_glitch_kv",   32'(kv_cnt - kv0), 32'd1);
        check("t6_glitch_xkey", 32'(xkey),         32'h1B29);
        check("t6_glitch_errs", 32'(fe_cnt - fe0 + pe_cnt - pe0), 32'd0);

        // 6b: reset mid-frame clears outputs at once and produces no pulse
        snap();
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        clr = 1'b1;
        #1;
        check("clr_xkey_async",  32'(xkey),                               32'h0);
        check("clr_pulses_zero", 32'({key_valid, parity_err, frame_err}), 32'h0);
        repeat (10) @(negedge clk);
        clr  = 1'b0;
        ps2d = 1'b1;
        repeat (TIMEOUT_CYC / 10) @(negedge clk);
        check("clr_no_pulse_kv",   32'(kv_cnt - kv0), 32'd0);
        check("clr_no_pulse_errs", 32'(fe_cnt - fe0 + pe_cnt - pe0), 32'd0);
        check("clr_xkey_held",     32'(xkey), 32'h0);
        send_frame(8'h29, 1'b0, 1'b1, -1);
        check("post_clr_xkey",     32'(xkey), 32'h0029);

        check("one_hot_pulses", 32'(multi_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
